// File: rtl/mem_data_ctrl_sb.sv
// ============================================================================
//  Module   : mem_data_ctrl_sb
//  Purpose  : MEM-stage data-memory controller with a posted store buffer.
//             Optional store-to-load forwarding is enabled by `define STB_FWD_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_data_ctrl_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [1:0]            cpu_size,
    input  logic                  cpu_signext,
    input  logic                  cpu_be,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_stall,
    output logic                  exc_adel,
    output logic                  exc_ades,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  sb_empty
);

    localparam int c_BYTES = DATA_W / 8;
    localparam int c_OFFW  = $clog2(c_BYTES);
    localparam int c_PTRW  = $clog2(SB_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                r_state;

    logic [ADDR_W-1:0]     r_sb_addr [SB_DEPTH];
    logic [DATA_W-1:0]     r_sb_data [SB_DEPTH];
    logic [c_BYTES-1:0]    r_sb_strb [SB_DEPTH];
    logic [c_PTRW-1:0]     r_rd_ptr;
    logic [c_PTRW-1:0]     r_wr_ptr;
    logic [c_PTRW:0]       r_count;

    logic [c_OFFW-1:0]     w_off;
    logic                  w_misalign;
    logic [3:0]            w_nbytes;
    logic [c_OFFW-1:0]     w_lane;
    logic [15:0]           w_mask16;
    logic [c_BYTES-1:0]    w_strb;
    logic [DATA_W-1:0]     w_wdata_rep;
    logic [ADDR_W-1:0]     w_addr_al;
    logic                  w_load;
    logic                  w_store;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_fwd_take;
    logic                  w_fwd_done;
    logic [DATA_W-1:0]     w_fwd_data;

    // Shift the selected lanes down, keep the access width and extend.
    function automatic logic [DATA_W-1:0] f_extract(
        input logic [DATA_W-1:0] d,
        input logic [c_OFFW-1:0] lane,
        input logic [1:0]        size,
        input logic              sx
    );
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] mask;
        logic              sign;
        sh = d >> {lane, 3'b000};
        case (size)
            2'd0:    begin mask = DATA_W'(8'hFF);         sign = sh[7];        end
            2'd1:    begin mask = DATA_W'(16'hFFFF);      sign = sh[15];       end
            2'd2:    begin mask = DATA_W'(32'hFFFF_FFFF); sign = sh[31];       end
            default: begin mask = '1;                     sign = sh[DATA_W-1]; end
        endcase
        return (sh & mask) | ((sx && sign) ? ~mask : '0);
    endfunction

    assign w_off     = cpu_addr[c_OFFW-1:0];
    assign w_nbytes  = 4'd1 << cpu_size;
    assign w_addr_al = {cpu_addr[ADDR_W-1:c_OFFW], {c_OFFW{1'b0}}};

    always_comb begin
        case (cpu_size)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = cpu_addr[0];
            2'd2:    w_misalign = |cpu_addr[1:0];
            default: w_misalign = (DATA_W == 32) ? 1'b1 : |cpu_addr[2:0];
        endcase
    end

    // Big endian puts byte offset 0 in the most significant lane.
    always_comb begin
        if (cpu_be) begin
            w_lane = c_OFFW'(c_BYTES - int'(w_off) - int'(w_nbytes));
        end else begin
            w_lane = w_off;
        end
    end

    assign w_mask16 = (16'd1 << w_nbytes) - 16'd1;
    assign w_strb   = c_BYTES'(w_mask16) << w_lane;

    always_comb begin
        case (cpu_size)
            2'd0:    w_wdata_rep = {c_BYTES{cpu_wdata[7:0]}};
            2'd1:    w_wdata_rep = {(c_BYTES/2){cpu_wdata[15:0]}};
            2'd2:    w_wdata_rep = {(c_BYTES/4){cpu_wdata[31:0]}};
            default: w_wdata_rep = cpu_wdata;
        endcase
    end

    assign w_load  = cpu_req & ~cpu_we & ~w_misalign;
    assign w_store = cpu_req &  cpu_we & ~w_misalign;
    assign w_full  = (r_count == (c_PTRW+1)'(SB_DEPTH));
    assign w_pop   = (r_state == S_WR) & mem_ack;
    // A full buffer can still take a store in the cycle its head drains.
    assign w_push  = w_store & (~w_full | w_pop);

    assign exc_adel = cpu_req & ~cpu_we & w_misalign;
    assign exc_ades = cpu_req &  cpu_we & w_misalign;

`ifdef STB_FWD_EN
    logic                  r_fwd_done;
    logic                  w_fwd_found;
    logic [c_PTRW-1:0]     w_fwd_idx;
    logic                  w_fwd_hit;

    // Later iterations are younger entries, so the last match wins.
    always_comb begin
        w_fwd_found = 1'b0;
        w_fwd_idx   = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (((c_PTRW+1)'(i) < r_count) &&
                (r_sb_addr[r_rd_ptr + c_PTRW'(i)][ADDR_W-1:c_OFFW] == cpu_addr[ADDR_W-1:c_OFFW])) begin
                w_fwd_found = 1'b1;
                w_fwd_idx   = r_rd_ptr + c_PTRW'(i);
            end
        end
    end

    assign w_fwd_hit  = w_fwd_found & ((r_sb_strb[w_fwd_idx] & w_strb) == w_strb);
    assign w_fwd_data = f_extract(r_sb_data[w_fwd_idx], w_lane, cpu_size, cpu_signext);
    assign w_fwd_take = w_load & w_fwd_hit & ~r_fwd_done &
                        (r_state != S_RESP) & (r_state != S_RD);
    assign w_fwd_done = r_fwd_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fwd_done <= 1'b0;
        end else begin
            r_fwd_done <= w_fwd_take;
        end
    end
`else
    assign w_fwd_take = 1'b0;
    assign w_fwd_done = 1'b0;
    assign w_fwd_data = '0;
`endif

    assign cpu_stall = (w_store & ~w_push) |
                       (w_load & (r_state != S_RESP) & ~w_fwd_done);
    assign sb_empty  = (r_count == '0) & (r_state != S_WR);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_sb_addr[r_wr_ptr] <= w_addr_al;
            r_sb_data[r_wr_ptr] <= w_wdata_rep;
            r_sb_strb[r_wr_ptr] <= w_strb;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            cpu_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Buffered stores always go out before a new load.
                    if (r_count != '0) begin
                        r_state   <= S_WR;
                        mem_wr    <= 1'b1;
                        mem_addr  <= r_sb_addr[r_rd_ptr];
                        mem_wdata <= r_sb_data[r_rd_ptr];
                        mem_wstrb <= r_sb_strb[r_rd_ptr];
                    end else if (w_load & ~w_fwd_done) begin
                        r_state   <= S_RD;
                        mem_rd    <= 1'b1;
                        mem_addr  <= w_addr_al;
                        mem_wstrb <= '0;
                    end
                end
                S_WR: begin
                    if (mem_ack) begin
                        r_state <= S_IDLE;
                        mem_wr  <= 1'b0;
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        r_state   <= S_RESP;
                        mem_rd    <= 1'b0;
                        cpu_rdata <= f_extract(mem_rdata, w_lane, cpu_size, cpu_signext);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_fwd_take) begin
                cpu_rdata <= w_fwd_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_data_ctrl_sb.sv
// ============================================================================
//  Module   : tb_mem_data_ctrl_sb
//  Purpose  : Scoreboard bench for mem_data_ctrl_sb with a reactive memory model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_data_ctrl_sb;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_signext, cpu_be;
    logic [AW-1:0] cpu_addr;
    logic [1:0]    cpu_size;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall, exc_adel, exc_ades;
    logic          mem_rd, mem_wr, mem_ack, sb_empty;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_wstrb;

    always #5 clock = ~clock;

    mem_data_ctrl_sb #(.DATA_W(DW), .ADDR_W(AW), .SB_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
        .cpu_signext(cpu_signext), .cpu_be(cpu_be), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .sb_empty(sb_empty)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    bit          ack_hold = 1'b0;
    int          ack_delay = 0;
    bit          stray = 1'b0;
    int          last_wait;
    logic        last_ack, last_adel, last_ades;
    wr_t         wr_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] mem_word [int];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reactive memory: acks after ack_delay cycles unless held.
    initial begin : g_mem_model
        int  cnt;
        bit  busy;
        wr_t w;
        logic [31:0] old;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        busy      = 1'b0;
        cnt       = 0;
        forever begin
            @(negedge clock);
            mem_ack = stray;
            stray   = 1'b0;
            if (reset || !(mem_rd || mem_wr)) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = 0;
                end
                if (!ack_hold && cnt >= ack_delay) begin
                    if (mem_wr) begin
                        if (wr_q.size() == 0) begin
                            chk("WR_UNEXPECTED", 64'd1, 64'd0);
                        end else begin
                            w = wr_q.pop_front();
                            chk("WR_ADDR", mem_addr, w.addr);
                            chk("WR_STRB", mem_wstrb, w.strb);
                            chk("WR_DATA", mem_wdata, w.data);
                        end
                        old = mem_word.exists(mem_addr >> 2) ? mem_word[mem_addr >> 2] : 32'h0;
                        for (int b = 0; b < 4; b++) begin
                            if (mem_wstrb[b]) old[8*b +: 8] = mem_wdata[8*b +: 8];
                        end
                        mem_word[mem_addr >> 2] = old;
                        n_wr++;
                    end else begin
                        chk("RD_ORDER", sb_empty, 1);
                        mem_rdata = mem_word.exists(mem_addr >> 2) ? mem_word[mem_addr >> 2] : 32'h0;
                        n_rd++;
                    end
                    mem_ack = 1'b1;
                    busy    = 1'b0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic sx, input logic be, input logic [31:0] wd);
        logic [31:0] word, exp_v, repl;
        logic [3:0]  strb;
        int          n, lane, nb;
        bit          mis;
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_size = size;
        cpu_signext = sx; cpu_be = be; cpu_wdata = wd;
        nb  = 1 << size;
        mis = (size == 2'd3) || ((addr % nb) != 0);
        if (!mis) begin
            lane = be ? (4 - int'(addr % 4) - nb) : int'(addr % 4);
            word = ref_mem.exists(addr >> 2) ? ref_mem[addr >> 2] : 32'h0;
            if (we) begin
                strb = 4'b0;
                for (int k = 0; k < nb; k++) begin
                    word[8*(lane+k) +: 8] = wd[8*k +: 8];
                    strb[lane+k] = 1'b1;
                end
                for (int b = 0; b < 4; b++) repl[8*b +: 8] = wd[8*(b % nb) +: 8];
                ref_mem[addr >> 2] = word;
                wr_q.push_back('{addr & ~32'h3, strb, repl});
            end else begin
                exp_v = 32'h0;
                for (int k = 0; k < nb; k++) exp_v[8*k +: 8] = word[8*(lane+k) +: 8];
                if (sx && exp_v[8*nb-1]) begin
                    for (int i = 8*nb; i < 32; i++) exp_v[i] = 1'b1;
                end
                exp_q.push_back(exp_v);
            end
        end
        #1;
        last_adel = exc_adel;
        last_ades = exc_ades;
        n = 0;
        while (cpu_stall && n < 300) begin
            @(negedge clock);
            #1;
            n++;
        end
        last_wait = n;
        last_ack  = mem_ack;
        if (n >= 300) begin
            chk("STALL_TIMEOUT", 64'd1, 64'd0);
        end else if (!we && !mis) begin
            exp_v = exp_q.pop_front();
            chk("LOAD_DATA", cpu_rdata, exp_v);
        end
        @(posedge clock);
        #1;
        cpu_req = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (!sb_empty && n < 300) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk(tag, sb_empty, 1);
    endtask

    initial begin : g_main
        int w0, r0, n;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_size = '0;
        cpu_signext = 1'b0; cpu_be = 1'b0; cpu_wdata = '0;

        repeat (3) @(negedge clock);
        #1;
        chk("RST_STALL", cpu_stall, 0);
        chk("RST_MEM_RD", mem_rd, 0);
        chk("RST_MEM_WR", mem_wr, 0);
        chk("RST_STRB", mem_wstrb, 0);
        chk("RST_RDATA", cpu_rdata, 0);
        chk("RST_SB_EMPTY", sb_empty, 1);
        reset = 1'b0;

        // Basic word store
        cpu_op(1'b1, 32'h100, 2'd2, 1'b0, 1'b1, 32'hDEADBEEF);
        chk("SW_NOSTALL", last_wait, 0);
        wait_empty("SW_SB_EMPTY");
        chk("SW_WR_COUNT", n_wr, 1);

        // Byte loads in both endiannesses
        mem_word[32'h100 >> 2] = 32'h1280_3456;
        ref_mem[32'h100 >> 2]  = 32'h1280_3456;
        cpu_op(1'b0, 32'h101, 2'd0, 1'b1, 1'b1, 32'h0);
        chk("LB_BE", cpu_rdata, 32'hFFFF_FF80);
        cpu_op(1'b0, 32'h101, 2'd0, 1'b1, 1'b0, 32'h0);
        chk("LB_LE", cpu_rdata, 32'h0000_0034);

        // Misaligned accesses
        w0 = n_wr;
        r0 = n_rd;
        cpu_op(1'b1, 32'h103, 2'd1, 1'b0, 1'b0, 32'h5555);
        chk("SH_ADES", last_ades, 1);
        chk("SH_NOSTALL", last_wait, 0);
        cpu_op(1'b0, 32'h102, 2'd2, 1'b0, 1'b0, 32'h0);
        chk("LW_ADEL", last_adel, 1);
        chk("LW_ADES_LOW", last_ades, 0);
        repeat (3) @(negedge clock);
        #1;
        chk("MIS_NO_WR", n_wr, w0);
        chk("MIS_NO_RD", n_rd, r0);
        chk("MIS_SB_EMPTY", sb_empty, 1);

        // Fill the buffer with acks held, then a fifth store
        ack_hold  = 1'b1;
        ack_delay = 0;
        for (int i = 0; i < 4; i++) begin
            cpu_op(1'b1, 32'h300 + i, 2'd0, 1'b0, i[0], 32'hA0 + i);
            chk("FILL_NOSTALL", last_wait, 0);
        end
        fork
            cpu_op(1'b1, 32'h304, 2'd2, 1'b0, 1'b0, 32'hCAFE_F00D);
            begin
                repeat (4) @(negedge clock);
                ack_hold = 1'b0;
            end
        join
        chk("FULL_STALL", last_wait >= 3, 1);
        chk("FULL_ACCEPT_ON_ACK", last_ack, 1);
        wait_empty("FULL_DRAIN");
        cpu_op(1'b0, 32'h300, 2'd2, 1'b0, 1'b1, 32'h0);

        // Store then load to the same word, slow memory
        ack_delay = 3;
        r0 = n_rd;
        w0 = n_wr;
        cpu_op(1'b1, 32'h200, 2'd2, 1'b0, 1'b1, 32'h1122_3344);
        cpu_op(1'b0, 32'h200, 2'd2, 1'b0, 1'b1, 32'h0);
        chk("SL_DATA", cpu_rdata, 32'h1122_3344);
`ifdef STB_FWD_EN
        chk("FWD_NO_RD", n_rd, r0);
        chk("FWD_LATENCY", last_wait, 1);
`else
        chk("SL_MEM_RD", n_rd, r0 + 1);
        chk("SL_WR_FIRST", n_wr, w0 + 1);
`endif
        wait_empty("SL_SB_EMPTY");

        // Random mixed traffic
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 2));
            a  = (32'h400 + 32'($urandom_range(0, 7))) & ~((32'd1 << sz) - 32'd1);
            ack_delay = $urandom_range(0, 3);
            cpu_op(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom);
        end
        wait_empty("RAND_DRAIN");

        // Reset while a write awaits its ack
        ack_hold  = 1'b1;
        ack_delay = 0;
        cpu_op(1'b1, 32'h500, 2'd2, 1'b0, 1'b0, 32'h5555_AAAA);
        cpu_op(1'b1, 32'h504, 2'd2, 1'b0, 1'b0, 32'h6666_BBBB);
        n = 0;
        while (!mem_wr && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("MID_WR_SEEN", mem_wr, 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("MID_RST_EMPTY", sb_empty, 1);
        chk("MID_RST_WR", mem_wr, 0);
        wr_q.delete();
        ref_mem.delete(32'h500 >> 2);
        ref_mem.delete(32'h504 >> 2);
        ack_hold = 1'b0;
        stray    = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("STRAY_WR", mem_wr, 0);
        chk("STRAY_RD", mem_rd, 0);
        chk("STRAY_EMPTY", sb_empty, 1);
        cpu_op(1'b0, 32'h200, 2'd2, 1'b0, 1'b1, 32'h0);
        chk("POST_RST_LOAD", cpu_rdata, 32'h1122_3344);

        chk("WRQ_DRAINED", wr_q.size(), 0);
        chk("EXPQ_DRAINED", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
